tpu_control_unit: RTL and testbench

// Sequencer for a WxW weight-stationary systolic TPU core. It queues 64-bit host GEMM commands
// D = A*B + C and, per command, drives the core: B-weight load, A streaming, C bias reads and
// D writeback addressing. It reports busy and raises a done interrupt per finished command.

---
 rtl/tpu_control_unit.sv | 178 +++++++++++++++++
 tb/tb_tpu_control_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_control_unit.sv
// Command sequencer for a weight-stationary systolic GEMM core: queues host commands and
// steps each one through weight load, bank switch, A/C streaming and D writeback counting.
module tpu_control_unit #(
   parameter int ADDR_WIDTH           = 10,
   parameter int SYSTOLIC_ARRAY_WIDTH = 16,
   parameter int CMD_FIFO_DEPTH       = 4,
   parameter int C_READ_DELAY         = 2*SYSTOLIC_ARRAY_WIDTH-1
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    cmd_valid,
   input  logic [63:0]                             cmd_data,
   output logic                                    cmd_ready,
   output logic                                    busy,
   output logic                                    done_irq,
   output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_a,
   output logic                                    ctrl_rd_en_a,
   output logic                                    ctrl_a_valid,
   output logic                                    ctrl_a_switch,
   output logic                                    ctrl_psum_valid,
   output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_b,
   output logic                                    ctrl_rd_en_b,
   output logic                                    ctrl_b_accept_w,
   output logic [$clog2(SYSTOLIC_ARRAY_WIDTH)-1:0] ctrl_b_weight_index,
   output logic [ADDR_WIDTH-1:0]                   ctrl_rd_addr_c,
   output logic                                    ctrl_rd_en_c,
   output logic                                    ctrl_c_valid,
   output logic [2:0]                              ctrl_vpu_mode,
   input  logic                                    core_writeback_valid,
   output logic [ADDR_WIDTH-1:0]                   ctrl_wr_addr_d,
   output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         ctrl_row_mask,
   output logic [SYSTOLIC_ARRAY_WIDTH-1:0]         ctrl_col_mask
);
   localparam int W  = SYSTOLIC_ARRAY_WIDTH;
   localparam int AW = ADDR_WIDTH;
   localparam int IW = $clog2(W);
   localparam int KW = $clog2(W + 1);
   localparam int W1 = W + 1;
   localparam int SW = $clog2(C_READ_DELAY + 256) + 1;
   localparam int PW = (CMD_FIFO_DEPTH > 1) ? $clog2(CMD_FIFO_DEPTH) : 1;
   localparam int FW = $clog2(CMD_FIFO_DEPTH + 1);

   typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, STREAM_A, DRAIN} state_t;

   function automatic logic [KW-1:0] clamp_w(input logic [7:0] len);
      if (32'(len) > W) return KW'(W);
      return KW'(len);
   endfunction

   function automatic logic [W-1:0] low_mask(input logic [KW-1:0] n);
      logic [W1-1:0] bit_n;
      bit_n = W1'(1) << n;
      return W'(bit_n - W1'(1));
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (32'(p) == CMD_FIFO_DEPTH - 1) ? '0 : p + PW'(1);
   endfunction

   state_t        state, state_d;
   logic [63:0]   fifo_mem [CMD_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [FW-1:0] fifo_cnt;
   logic          fifo_empty, push, pop, head_skip, finish;
   logic [63:0]   head;
   logic [7:0]    job_m, wb_row_cnt;
   logic [KW-1:0] job_kc, job_nc, ld_cnt;
   logic [AW-1:0] job_a, job_b, job_c, job_d;
   logic          job_skip;
   logic [SW-1:0] st_cnt, st_last, c_first, c_end;

   assign fifo_empty = (fifo_cnt == '0);
   assign cmd_ready  = (fifo_cnt != FW'(CMD_FIFO_DEPTH)) && !rst;
   assign push       = cmd_valid && cmd_ready;
   assign pop        = (state == IDLE) && !fifo_empty;
   assign head       = fifo_mem[rd_ptr];
   // Zero-length jobs never touch the SRAMs and retire straight from DRAIN.
   assign head_skip  = (head[7:0] == 8'd0) || (head[15:8] == 8'd0);

   assign c_first = SW'(C_READ_DELAY);
   assign c_end   = c_first + SW'(job_m);
   assign st_last = c_end - SW'(1);
   assign finish  = (state == DRAIN) &&
                    (job_skip || (wb_row_cnt == job_m) ||
                     (core_writeback_valid && (9'(wb_row_cnt) + 9'd1 == 9'(job_m))));

   always_comb begin
      state_d = state;
      case (state)
         IDLE:     if (pop) state_d = head_skip ? DRAIN : LOAD_W;
         LOAD_W:   if (ld_cnt == job_kc) state_d = SWITCH;
         SWITCH:   state_d = STREAM_A;
         STREAM_A: if (st_cnt == st_last) state_d = DRAIN;
         DRAIN:    if (finish) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      ctrl_rd_en_b   = (state == LOAD_W) && (ld_cnt < job_kc);
      ctrl_rd_addr_b = '0;
      if (ctrl_rd_en_b) ctrl_rd_addr_b = job_b + AW'(ld_cnt);
      ctrl_rd_en_a   = (state == STREAM_A) && (st_cnt < SW'(job_m));
      ctrl_rd_addr_a = '0;
      if (ctrl_rd_en_a) ctrl_rd_addr_a = job_a + AW'(st_cnt);
      ctrl_rd_en_c   = (state == STREAM_A) && (st_cnt >= c_first) && (st_cnt < c_end);
      ctrl_rd_addr_c = '0;
      if (ctrl_rd_en_c) ctrl_rd_addr_c = job_c + AW'(st_cnt - c_first);
      ctrl_a_switch  = (state == SWITCH);
      ctrl_vpu_mode  = {2'b00, state != IDLE};
      ctrl_row_mask  = '0;
      ctrl_col_mask  = '0;
      ctrl_wr_addr_d = '0;
      if (state != IDLE) begin
         ctrl_row_mask  = low_mask(job_kc);
         ctrl_col_mask  = low_mask(job_nc);
         ctrl_wr_addr_d = job_d + AW'(wb_row_cnt);
      end
      done_irq = finish && !rst;
      busy     = (state != IDLE) || !fifo_empty || push;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= IDLE;
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         fifo_cnt            <= '0;
         ld_cnt              <= '0;
         st_cnt              <= '0;
         wb_row_cnt          <= '0;
         job_skip            <= 1'b0;
         ctrl_a_valid        <= 1'b0;
         ctrl_psum_valid     <= 1'b0;
         ctrl_b_accept_w     <= 1'b0;
         ctrl_b_weight_index <= '0;
         ctrl_c_valid        <= 1'b0;
      end else begin
         state <= state_d;
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop) begin
            rd_ptr   <= ptr_inc(rd_ptr);
            job_skip <= head_skip;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + FW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - FW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
         ld_cnt <= (state == LOAD_W && state_d == LOAD_W) ? ld_cnt + KW'(1) : '0;
         st_cnt <= (state == STREAM_A && state_d == STREAM_A) ? st_cnt + SW'(1) : '0;
         if (finish)
            wb_row_cnt <= '0;
         else if ((state == STREAM_A || state == DRAIN) && core_writeback_valid)
            wb_row_cnt <= wb_row_cnt + 8'd1;
         // SRAM read latency stage: valids trail their read enables by one cycle
         ctrl_a_valid        <= ctrl_rd_en_a;
         ctrl_psum_valid     <= ctrl_rd_en_a;
         ctrl_b_accept_w     <= ctrl_rd_en_b;
         ctrl_b_weight_index <= ctrl_rd_en_b ? IW'(ld_cnt) : '0;
         ctrl_c_valid        <= ctrl_rd_en_c;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_data;
      if (pop) begin
         job_m  <= head[7:0];
         job_kc <= clamp_w(head[15:8]);
         job_nc <= clamp_w(head[23:16]);
         job_a  <= head[24 +: AW];
         job_b  <= head[24 + AW +: AW];
         job_c  <= head[24 + 2*AW +: AW];
         job_d  <= head[24 + 3*AW +: AW];
      end
   end

endmodule

// File: tb/tb_tpu_control_unit.sv
// Directed bench for tpu_control_unit: table of single commands, then back-to-back,
// FIFO-full and mid-job reset sequences, with the core's writeback modelled from c_valid.
module tb_tpu_control_unit;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic [63:0]   cmd_data;
   logic          cmd_ready, busy, done_irq;
   logic [AW-1:0] ctrl_rd_addr_a, ctrl_rd_addr_b, ctrl_rd_addr_c, ctrl_wr_addr_d;
   logic          ctrl_rd_en_a, ctrl_a_valid, ctrl_a_switch, ctrl_psum_valid;
   logic          ctrl_rd_en_b, ctrl_b_accept_w, ctrl_rd_en_c, ctrl_c_valid;
   logic [3:0]    ctrl_b_weight_index;
   logic [2:0]    ctrl_vpu_mode;
   logic          core_writeback_valid = 1'b0;
   logic [15:0]   ctrl_row_mask, ctrl_col_mask;

   always #5 clk = ~clk;

   tpu_control_unit dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
      .busy(busy), .done_irq(done_irq),
      .ctrl_rd_addr_a(ctrl_rd_addr_a), .ctrl_rd_en_a(ctrl_rd_en_a), .ctrl_a_valid(ctrl_a_valid),
      .ctrl_a_switch(ctrl_a_switch), .ctrl_psum_valid(ctrl_psum_valid),
      .ctrl_rd_addr_b(ctrl_rd_addr_b), .ctrl_rd_en_b(ctrl_rd_en_b),
      .ctrl_b_accept_w(ctrl_b_accept_w), .ctrl_b_weight_index(ctrl_b_weight_index),
      .ctrl_rd_addr_c(ctrl_rd_addr_c), .ctrl_rd_en_c(ctrl_rd_en_c), .ctrl_c_valid(ctrl_c_valid),
      .ctrl_vpu_mode(ctrl_vpu_mode), .core_writeback_valid(core_writeback_valid),
      .ctrl_wr_addr_d(ctrl_wr_addr_d), .ctrl_row_mask(ctrl_row_mask), .ctrl_col_mask(ctrl_col_mask)
   );

   wire any_out = busy | done_irq | (|ctrl_rd_addr_a) | ctrl_rd_en_a | ctrl_a_valid |
                  ctrl_a_switch | ctrl_psum_valid | (|ctrl_rd_addr_b) | ctrl_rd_en_b |
                  ctrl_b_accept_w | (|ctrl_b_weight_index) | (|ctrl_rd_addr_c) | ctrl_rd_en_c |
                  ctrl_c_valid | (|ctrl_vpu_mode) | (|ctrl_wr_addr_d) | (|ctrl_row_mask) |
                  (|ctrl_col_mask);

   int nvec = 0, nmis = 0;
   int cyc = 0, ncmd, nb, na, nc, nacc, nsw, nwb, ndone, idx_bad, align_bad;
   int acc_cyc, last_acc_cyc, sw_cyc, first_a_cyc, first_c_cyc, done_cyc;
   logic [AW-1:0] b_first, b_last, a_first, a_last, c_first, c_last;
   logic [15:0]   rmask, cmask;
   logic [AW-1:0] wb_addr [64];
   logic          prev_b = 1'b0, prev_a = 1'b0, prev_c = 1'b0;
   logic          wb_en = 1'b1, wb_force = 1'b0;

   // Core model: one D row written back per aligned bias row.
   always @(posedge clk) begin
      #2;
      core_writeback_valid = (wb_en && ctrl_c_valid) || wb_force;
   end

   always @(negedge clk) begin
      cyc++;
      if (cmd_valid && cmd_ready) begin ncmd++; acc_cyc = cyc; end
      if (ctrl_rd_en_b) begin
         if (nb == 0) b_first = ctrl_rd_addr_b;
         b_last = ctrl_rd_addr_b; nb++;
      end
      if (ctrl_b_accept_w !== prev_b) align_bad++;
      if (ctrl_b_accept_w) begin
         if (ctrl_b_weight_index != 4'(nacc)) idx_bad++;
         nacc++; last_acc_cyc = cyc;
      end
      if (ctrl_a_switch) begin nsw++; sw_cyc = cyc; end
      if (ctrl_rd_en_a) begin
         if (na == 0) begin a_first = ctrl_rd_addr_a; first_a_cyc = cyc; end
         a_last = ctrl_rd_addr_a; na++;
      end
      if (ctrl_a_valid !== prev_a || ctrl_psum_valid !== prev_a) align_bad++;
      if (ctrl_rd_en_c) begin
         if (nc == 0) begin c_first = ctrl_rd_addr_c; first_c_cyc = cyc; end
         c_last = ctrl_rd_addr_c; nc++;
      end
      if (ctrl_c_valid !== prev_c) align_bad++;
      if (core_writeback_valid) begin
         if (nwb < 64) wb_addr[nwb] = ctrl_wr_addr_d;
         nwb++;
      end
      if (done_irq) begin ndone++; done_cyc = cyc; end
      if (ctrl_vpu_mode == 3'd1) begin rmask = ctrl_row_mask; cmask = ctrl_col_mask; end
      prev_b = ctrl_rd_en_b; prev_a = ctrl_rd_en_a; prev_c = ctrl_rd_en_c;
   end

   task automatic clear_log();
      ncmd = 0; nb = 0; na = 0; nc = 0; nacc = 0; nsw = 0; nwb = 0; ndone = 0;
      idx_bad = 0; align_bad = 0; rmask = '0; cmask = '0;
      acc_cyc = 0; last_acc_cyc = 0; sw_cyc = 0; first_a_cyc = 0; first_c_cyc = 0; done_cyc = 0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk(input int m, k, n, input logic [AW-1:0] a, b, c, d);
      return {d, c, b, a, 8'(n), 8'(k), 8'(m)};
   endfunction

   // Called just after a rising edge; returns with the command accepted or the budget spent.
   task automatic push(input logic [63:0] d, input int budget, output bit ok);
      cmd_data = d; cmd_valid = 1'b1; ok = 1'b0;
      for (int t = 0; t < budget && !ok; t++) begin
         @(negedge clk); ok = cmd_ready;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int n, input int budget);
      for (int t = 0; t < budget && ndone < n; t++) begin @(posedge clk); #1; end
   endtask

   typedef struct {
      int m, k, n;
      logic [AW-1:0] a, b, c, d;
      int enb, ena;
      logic [AW-1:0] eb0, eb1, ea0, ea1, ec0, ec1, ed1;
      logic [15:0] erm, ecm;
   } vec_t;
   vec_t vt [5];

   initial begin
      bit ok, ok2;
      vt[0] = '{16, 8, 8, 10'h100, 10'h200, 10'h300, 10'h400, 8, 16,
                10'h200, 10'h207, 10'h100, 10'h10F, 10'h300, 10'h30F, 10'h40F, 16'h00FF, 16'h00FF};
      vt[1] = '{3, 20, 40, 10'h3FF, 10'h3FE, 10'h3FD, 10'h3FF, 16, 3,
                10'h3FE, 10'h00D, 10'h3FF, 10'h001, 10'h3FD, 10'h3FF, 10'h001, 16'hFFFF, 16'hFFFF};
      vt[2] = '{1, 1, 3, 10'h010, 10'h020, 10'h030, 10'h040, 1, 1,
                10'h020, 10'h020, 10'h010, 10'h010, 10'h030, 10'h030, 10'h040, 16'h0001, 16'h0007};
      vt[3] = '{5, 0, 4, 10'h050, 10'h060, 10'h070, 10'h080, 0, 0,
                10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 16'h0000, 16'h000F};
      vt[4] = '{0, 4, 16, 10'h050, 10'h060, 10'h070, 10'h080, 0, 0,
                10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 16'h000F, 16'hFFFF};

      rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0;
      clear_log();
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", any_out, 0);
      chk("reset_cmd_ready", cmd_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", cmd_ready, 1);
      chk("post_reset_busy", busy, 0);
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         clear_log();
         push(mk(vt[i].m, vt[i].k, vt[i].n, vt[i].a, vt[i].b, vt[i].c, vt[i].d), 5, ok);
         chk($sformatf("v%0d_accept", i), ok, 1);
         wait_done(1, 400);
         repeat (3) @(posedge clk);
         #1;
         chk($sformatf("v%0d_done", i), ndone, 1);
         chk($sformatf("v%0d_b_reads", i), nb, vt[i].enb);
         chk($sformatf("v%0d_a_reads", i), na, vt[i].ena);
         chk($sformatf("v%0d_c_reads", i), nc, vt[i].ena);
         chk($sformatf("v%0d_writebacks", i), nwb, vt[i].ena);
         chk($sformatf("v%0d_idx", i), idx_bad, 0);
         chk($sformatf("v%0d_align", i), align_bad, 0);
         chk($sformatf("v%0d_row_mask", i), rmask, vt[i].erm);
         chk($sformatf("v%0d_col_mask", i), cmask, vt[i].ecm);
         chk($sformatf("v%0d_switches", i), nsw, (vt[i].enb > 0) ? 1 : 0);
         if (vt[i].enb > 0) begin
            chk($sformatf("v%0d_b_first", i), b_first, vt[i].eb0);
            chk($sformatf("v%0d_b_last", i), b_last, vt[i].eb1);
            chk($sformatf("v%0d_a_first", i), a_first, vt[i].ea0);
            chk($sformatf("v%0d_a_last", i), a_last, vt[i].ea1);
            chk($sformatf("v%0d_c_first", i), c_first, vt[i].ec0);
            chk($sformatf("v%0d_c_last", i), c_last, vt[i].ec1);
            chk($sformatf("v%0d_d_first", i), wb_addr[0], vt[i].d);
            chk($sformatf("v%0d_d_last", i), wb_addr[vt[i].ena-1], vt[i].ed1);
            chk($sformatf("v%0d_switch_lat", i), sw_cyc - last_acc_cyc, 1);
            chk($sformatf("v%0d_c_delay", i), first_c_cyc - first_a_cyc, 31);
         end else begin
            chk($sformatf("v%0d_skip_done_lat", i), done_cyc - acc_cyc, 2);
         end
         chk($sformatf("v%0d_idle_busy", i), busy, 0);
         chk($sformatf("v%0d_idle_mode", i), ctrl_vpu_mode, 0);
         chk($sformatf("v%0d_idle_mask", i), ctrl_row_mask | ctrl_col_mask, 0);
      end

      // Two commands back to back: no stall, jobs retire in order.
      clear_log();
      push(mk(16, 8, 8, 10'h100, 10'h200, 10'h300, 10'h400), 1, ok);
      push(mk(16, 8, 8, 10'h120, 10'h200, 10'h300, 10'h420), 1, ok2);
      chk("b2b_accept1", ok, 1);
      chk("b2b_accept2", ok2, 1);
      wait_done(2, 600);
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_done", ndone, 2);
      chk("b2b_switches", nsw, 2);
      chk("b2b_a_last", a_last, 10'h12F);
      chk("b2b_wb", nwb, 32);
      chk("b2b_d0", wb_addr[0], 10'h400);
      chk("b2b_d15", wb_addr[15], 10'h40F);
      chk("b2b_d16", wb_addr[16], 10'h420);
      chk("b2b_d31", wb_addr[31], 10'h42F);

      // FIFO full while the first job waits in DRAIN for writebacks.
      clear_log();
      wb_en = 1'b0;
      for (int j = 0; j < 5; j++) begin
         push(mk(1, 1, 1, 10'(j), 10'h10, 10'h20, 10'h30), 1, ok);
         chk($sformatf("fill_accept%0d", j), ok, 1);
      end
      @(negedge clk);
      chk("full_ready", cmd_ready, 0);
      @(posedge clk); #1;
      push(mk(1, 1, 1, 10'h5, 10'h10, 10'h20, 10'h30), 10, ok);
      chk("full_reject", ok, 0);
      chk("full_cmd_count", ncmd, 5);
      for (int t = 0; t < 200 && nc < 1; t++) begin @(posedge clk); #1; end
      repeat (3) @(posedge clk);
      #1;
      chk("stalled_no_done", ndone, 0);
      chk("stalled_busy", busy, 1);
      wb_en = 1'b1; wb_force = 1'b1;
      @(posedge clk); #1 wb_force = 1'b0;
      push(mk(1, 1, 1, 10'h5, 10'h10, 10'h20, 10'h30), 300, ok);
      chk("refill_accept", ok, 1);
      wait_done(6, 800);
      repeat (3) @(posedge clk);
      #1;
      chk("fifo_done", ndone, 6);
      chk("fifo_cmd_count", ncmd, 6);
      chk("fifo_idle_busy", busy, 0);

      // Reset in the middle of A streaming aborts the job silently.
      clear_log();
      push(mk(16, 8, 8, 10'h100, 10'h200, 10'h300, 10'h400), 5, ok);
      for (int t = 0; t < 200 && na < 1; t++) begin @(posedge clk); #1; end
      chk("abort_streaming", na > 0, 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_outputs", any_out, 0);
      chk("abort_ready_in_rst", cmd_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (80) @(posedge clk);
      #1;
      chk("abort_no_done", ndone, 0);
      chk("abort_outputs_after", any_out, 0);
      chk("abort_ready", cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
